// File: rtl/cpu_fetch.sv
// Instruction fetch stage. It issues one word read at a time and holds the
// returned word for decode until decode accepts it. A read that goes
// unanswered for TIMEOUT cycles is dropped. The stage then idles for one
// cycle and reissues the read at the same address.
//
// Handshake: imem_req is held high with a stable imem_addr until the first
// cycle that has imem_ack=1 (the transfer happens in that cycle) or until the
// timeout. Decode accepts the held word in any HOLD cycle with stall=0.
module cpu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        do_jump,
  input  logic        alu_jump,
  input  logic        branch_taken,
  input  logic [31:0] jump_address,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [7:0]  retry_count,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_RETRY = 2'd2
  } state_t;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  state_t      state_q;
  state_t      state_d;
  logic [31:0] fetch_pc;
  logic [15:0] wait_cnt;
  logic        timeout_hit;
  logic        take_jump;
  logic [31:0] next_addr;

  assign timeout_hit = (wait_cnt == WAIT_LAST);
  assign take_jump   = do_jump && (!alu_jump || branch_taken);
  assign next_addr   = take_jump ? jump_address : (pc + 32'd1);

  assign imem_req    = (state_q == ST_FETCH);
  assign imem_addr   = fetch_pc;
  assign instr_valid = (state_q == ST_HOLD);
  assign state_dbg   = state_q;

  // State register. Reset parks the machine in RETRY, which is the idle
  // state with no request. The first edge after release therefore enters
  // FETCH at RESET_PC without counting a retry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RETRY;
    else        state_q <= state_d;
  end

  // Next-state logic. An ack wins over a timeout that occurs in the same cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_FETCH: begin
        if (imem_ack)         state_d = ST_HOLD;
        else if (timeout_hit) state_d = ST_RETRY;
      end
      ST_HOLD:  if (!stall) state_d = ST_FETCH;
      ST_RETRY: state_d = ST_FETCH;
      default:  state_d = ST_FETCH;
    endcase
  end

  // Datapath: captures the fetched word, steps the PC, and runs the wait and retry counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      wait_cnt    <= 16'd0;
      instruction <= 32'd0;
      pc          <= RESET_PC;
      retry_count <= 8'd0;
    end else begin
      unique case (state_q)
        ST_FETCH: begin
          if (imem_ack) begin
            instruction <= imem_rdata;
            pc          <= fetch_pc;
            wait_cnt    <= 16'd0;
          end else if (timeout_hit) begin
            wait_cnt <= 16'd0;
            if (retry_count != 8'hFF) retry_count <= retry_count + 8'd1;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        ST_HOLD: begin
          if (!stall) fetch_pc <= next_addr;
        end
        ST_RETRY: wait_cnt <= 16'd0;
        default:  wait_cnt <= 16'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_fetch.sv
// Randomized bench for cpu_fetch. A transaction-level model predicts every
// fetch address. A scoreboard queue holds each acknowledged word until decode
// consumes it.
module tb_cpu_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          TO     = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        stall = 1'b0;
  logic        do_jump = 1'b0;
  logic        alu_jump = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] jump_address = 32'd0;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [31:0] pc;
  logic [7:0]  retry_count;
  logic [1:0]  state_dbg;

  cpu_fetch #(.RESET_PC(RST_PC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .do_jump(do_jump), .alu_jump(alu_jump),
    .branch_taken(branch_taken), .jump_address(jump_address),
    .instruction(instruction), .instr_valid(instr_valid), .pc(pc),
    .retry_count(retry_count), .state_dbg(state_dbg)
  );

  // scoreboard and reference model
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];   // words acked but not yet consumed
  logic [31:0] pc_q[$];    // their addresses
  typedef enum int {M_FETCH, M_HOLD, M_IDLE} mphase_t;
  mphase_t     m_phase;
  logic [31:0] m_addr;     // address the next or current request must use
  int          m_wait;     // request cycles without ack so far
  int          m_retry;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%h exp=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    pc_q.delete();
    m_addr  = RST_PC;
    m_wait  = 0;
    m_retry = 0;
    m_phase = M_IDLE;
  endtask

  // Asserts reset mid-cycle, checks the forced outputs at once, and offers an
  // ack that must be ignored. Release happens on a falling edge, so the next
  // rising edge starts the fetch at RST_PC.
  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst_req",   32'(imem_req), 32'd0);
    check_eq("rst_addr",  imem_addr, RST_PC);
    check_eq("rst_instr", instruction, 32'd0);
    check_eq("rst_valid", 32'(instr_valid), 32'd0);
    check_eq("rst_pc",    pc, RST_PC);
    check_eq("rst_retry", 32'(retry_count), 32'd0);
    imem_ack   = 1'b1;
    imem_rdata = $urandom;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ack_ignored_valid", 32'(instr_valid), 32'd0);
    check_eq("rst_ack_ignored_req",   32'(imem_req), 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    imem_ack = 1'b0;
    model_reset();
    m_phase = M_FETCH;  // the coming edge enters FETCH
  endtask

  // Waits, with a bound, until a request is outstanding, then resets while it is pending.
  task automatic reset_in_fetch();
    imem_ack = 1'b0;
    stall    = 1'b0;
    for (int i = 0; i < 20 && !imem_req; i++) begin
      @(posedge clk);
      #1;
    end
    check_eq("req_before_rst", 32'(imem_req), 32'd1);
    apply_reset();
  endtask

  // One iteration per cycle: compare on the falling edge, drive random inputs, then predict the next rising edge.
  task automatic run_cycles(input int n, input int ack_pct, input int stall_pct,
                            input int jump_pct, input bit seq_data);
    bit take;
    repeat (n) begin
      @(negedge clk);
      check_eq("req",   32'(imem_req), 32'(m_phase == M_FETCH));
      check_eq("valid", 32'(instr_valid), 32'(m_phase == M_HOLD));
      check_eq("retry_count", 32'(retry_count), 32'(m_retry));
      if (m_phase == M_FETCH) check_eq("imem_addr", imem_addr, m_addr);
      if (m_phase == M_HOLD && exp_q.size() > 0) begin
        check_eq("instruction", instruction, exp_q[0]);
        check_eq("pc", pc, pc_q[0]);
      end

      imem_ack     = ($urandom_range(99) < ack_pct);
      imem_rdata   = seq_data ? (m_addr + 32'h100) : $urandom;
      stall        = ($urandom_range(99) < stall_pct);
      do_jump      = ($urandom_range(99) < jump_pct);
      alu_jump     = $urandom_range(1);
      branch_taken = $urandom_range(1);
      jump_address = ($urandom_range(3) == 0) ? 32'hFFFF_FFFF : $urandom;

      case (m_phase)
        M_FETCH: begin
          if (imem_ack) begin
            exp_q.push_back(imem_rdata);
            pc_q.push_back(m_addr);
            m_phase = M_HOLD;
            m_wait  = 0;
          end else if (m_wait == TO - 1) begin
            m_phase = M_IDLE;
            m_wait  = 0;
            if (m_retry < 255) m_retry++;
          end else begin
            m_wait++;
          end
        end
        M_HOLD: begin
          if (!stall) begin
            take    = do_jump && (!alu_jump || branch_taken);
            m_addr  = take ? jump_address : pc_q[0] + 32'd1;
            void'(exp_q.pop_front());
            void'(pc_q.pop_front());
            m_phase = M_FETCH;
          end
        end
        default: m_phase = M_FETCH;
      endcase
    end
  endtask

  initial begin
    model_reset();
    #3;
    apply_reset();
    // In-order fetch with every request acked and data equal to address + 0x100.
    run_cycles(12, 100, 0, 0, 1'b1);
    // Random acks, stalls, and jumps. Some jumps target 0xFFFF_FFFF to exercise PC wrap.
    run_cycles(400, 60, 30, 30, 1'b0);
    // No acks, so requests time out and are retried.
    run_cycles(40, 0, 0, 0, 1'b0);
    run_cycles(100, 40, 20, 40, 1'b0);
    reset_in_fetch();
    run_cycles(200, 50, 40, 50, 1'b0);
    apply_reset();
    // A long run with no acks drives retry_count into saturation.
    run_cycles(1350, 0, 0, 0, 1'b0);
    check_eq("retry_saturated", 32'(retry_count), 32'd255);
    run_cycles(200, 70, 30, 50, 1'b0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cpu_fetch.md
CPU_FETCH -- requirements
Module: cpu_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the word address of the first instruction fetched after reset.
REQ-002 Parameter TIMEOUT, default 16, is the number of cycles a fetch may wait for imem_ack before it is reissued.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 imem_req  output  1  instruction-memory read request.
REQ-006 imem_addr  output  32  word address of the requested instruction.
REQ-007 imem_ack  input  1  memory returns data this cycle.
REQ-008 imem_rdata  input  32  instruction word; sampled only when imem_ack=1.
REQ-009 stall  input  1  downstream decode cannot consume the held instruction.
REQ-010 do_jump  input  1  control flow change requested for the held instruction.
REQ-011 alu_jump  input  1  jump is conditional on branch_taken.
REQ-012 branch_taken  input  1  ALU comparison result for a conditional jump.
REQ-013 jump_address  input  32  target word address.
REQ-014 instruction  output  32  held instruction word, feeding decode.
REQ-015 instr_valid  output  1  instruction holds a fetched word.
REQ-016 pc  output  32  word address of the held instruction.
REQ-017 retry_count  output  8  saturating count of timed-out fetches since reset.

Function
REQ-018 The FSM SHALL have three states: FETCH (imem_req=1), HOLD (instr_valid=1) and RETRY (one idle cycle with imem_req=0).
REQ-019 In FETCH, imem_addr SHALL equal the internal fetch PC and stay stable until imem_ack or timeout.
REQ-020 In FETCH with imem_ack=1, the block SHALL latch imem_rdata into instruction, latch the fetch PC into pc, and enter HOLD on the next edge.
REQ-021 An ack on the same cycle that FETCH is entered SHALL be accepted, giving a minimum latency of 1 cycle from request to instr_valid.
REQ-022 imem_ack SHALL be ignored in HOLD and RETRY.
REQ-023 In FETCH, a wait counter SHALL increment each cycle without ack; on reaching TIMEOUT-1 with no ack, the FSM SHALL enter RETRY.
REQ-024 On entering RETRY, retry_count SHALL increment, saturating at 8'hFF.
REQ-025 RETRY SHALL return to FETCH on the next cycle with the same address and a cleared wait counter.
REQ-026 In HOLD with stall=1, the state, instruction and pc SHALL be unchanged.
REQ-027 In HOLD with stall=0, the block SHALL compute the next address, load it into the fetch PC, and enter FETCH.
REQ-028 The next address SHALL be jump_address when do_jump=1 and (alu_jump=0 or branch_taken=1); otherwise it SHALL be pc+1.
REQ-029 pc+1 SHALL wrap modulo 2^32, so 32'hFFFF_FFFF is followed by 32'h0000_0000.
REQ-030 do_jump, alu_jump, branch_taken and jump_address SHALL be ignored outside HOLD, and also in HOLD while stall=1.
REQ-031 instr_valid SHALL be 1 only in HOLD.
REQ-032 Each fetched word SHALL be presented to decode exactly once, with no duplicates and no drops.

Reset
REQ-033 While rst_n=0, the outputs SHALL be forced immediately to: imem_req=0, imem_addr=RESET_PC, instruction=0, instr_valid=0, pc=RESET_PC, retry_count=0; the fetch PC SHALL be RESET_PC and the wait counter 0.
REQ-034 On the first rising edge after rst_n deasserts, the FSM SHALL enter FETCH at RESET_PC.
REQ-035 Reset asserted mid-fetch or mid-hold SHALL abandon the transaction, and any ack arriving during reset SHALL be ignored.

Verification
REQ-036 Sequential fetch: reset, then ack every request with rdata=addr+0x100 and stall=0 -> pc sequence is 0,1,2,3 and instruction sequence is 0x100,0x101,0x102,0x103, each valid for one cycle.
REQ-037 Unconditional jump: at pc=2, set do_jump=1, alu_jump=0, jump_address=0x40 -> next imem_addr=0x40; with alu_jump=1 and branch_taken=0 instead -> next imem_addr=3.
REQ-038 Stall: hold stall=1 for 5 cycles at pc=1 -> instruction, pc and instr_valid=1 unchanged, imem_req=0; release stall -> imem_addr=2.
REQ-039 Timeout: with TIMEOUT=4 and no ack -> imem_req high for 4 cycles, low for 1 cycle, then reissued at the same address; retry_count=1.
REQ-040 Wrap and reset: jump to 0xFFFF_FFFF then consume -> next imem_addr=0; assert rst_n=0 while imem_req=1 -> imem_req=0 with no clock edge, and the first fetch after release is at RESET_PC.
